// File: rtl/lane_sequencer_if.sv
// Bundle of command, operand-memory, lane and status signals for lane_sequencer.
// The slave side is the sequencer; the master side is the environment that feeds it.
interface lane_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_select;
    logic [7:0]        cmd_key;
    logic [ADDR_W-1:0] cmd_src_a;
    logic [ADDR_W-1:0] cmd_src_b;
    logic [ADDR_W-1:0] cmd_dst;
    logic [4:0]        cmd_len;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data;

    logic [7:0]        lane_data1;
    logic [7:0]        lane_data2;
    logic [7:0]        lane_key;
    logic [3:0]        lane_select;
    logic [7:0]        lane_result;

    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [7:0]        mem_wr_data;

    logic              busy;
    logic              done;

    modport master (
        output cmd_valid, cmd_select, cmd_key, cmd_src_a, cmd_src_b, cmd_dst, cmd_len,
        input  cmd_ready,
        input  mem_rd_en, mem_rd_addr,
        output mem_rd_data,
        input  lane_data1, lane_data2, lane_key, lane_select,
        output lane_result,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        input  busy, done
    );

    modport slave (
        input  cmd_valid, cmd_select, cmd_key, cmd_src_a, cmd_src_b, cmd_dst, cmd_len,
        output cmd_ready,
        output mem_rd_en, mem_rd_addr,
        input  mem_rd_data,
        output lane_data1, lane_data2, lane_key, lane_select,
        input  lane_result,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        output busy, done
    );
endinterface

// File: rtl/lane_sequencer.sv
// Vector sequencer: per element reads A[i] and B[i], presents them to a combinational
// lane and writes the lane result to dst+i; one element every four cycles.
module lane_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int MAX_LEN = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    lane_sequencer_if.slave bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD_A = 3'd1;
    localparam logic [2:0] S_RD_B = 3'd2;
    localparam logic [2:0] S_EXEC = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [4:0] MAX_LEN_C = 5'(MAX_LEN);

    logic [2:0]        state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [4:0]        len_q;
    logic [4:0]        len_eff;
    logic [3:0]        sel_q;
    logic [7:0]        key_q;
    logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q;
    logic [7:0]        data1_q, data2_q;

    logic              handshake;
    logic              last_elem;
    logic [ADDR_W-1:0] idx_ext;
    logic              rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr, wr_addr;

    assign handshake = bus.cmd_valid && (state_q == S_IDLE);
    assign len_eff   = (bus.cmd_len > MAX_LEN_C) ? MAX_LEN_C : bus.cmd_len;
    assign last_elem = (idx_q == len_q - 5'd1);
    assign idx_ext   = ADDR_W'(idx_q);

    // NOTE: every variable driven in an always_comb gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    idx_d   = '0;
                    state_d = (len_eff == 5'd0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A: state_d = S_RD_B;
            S_RD_B: state_d = S_EXEC;
            S_EXEC: state_d = S_WB;
            S_WB: begin
                if (last_elem) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = S_RD_A;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            sel_q   <= '0;
            key_q   <= '0;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (handshake) begin
                len_q   <= len_eff;
                sel_q   <= bus.cmd_select;
                key_q   <= bus.cmd_key;
                src_a_q <= bus.cmd_src_a;
                src_b_q <= bus.cmd_src_b;
                dst_q   <= bus.cmd_dst;
            end
            // Read data lags the strobe by one cycle, hence A lands in RD_B and B in EXEC.
            if (state_q == S_RD_B) begin
                data1_q <= bus.mem_rd_data;
            end
            if (state_q == S_EXEC) begin
                data2_q <= bus.mem_rd_data;
            end
        end
    end

    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        case (state_q)
            S_RD_A: begin
                rd_en   = 1'b1;
                rd_addr = src_a_q + idx_ext;
            end
            S_RD_B: begin
                rd_en   = 1'b1;
                rd_addr = src_b_q + idx_ext;
            end
            S_WB: begin
                wr_en   = 1'b1;
                wr_addr = dst_q + idx_ext;
            end
            default: ;
        endcase
    end

    // Outputs are qualified by rst_n so an asserted reset silences strobes in the same cycle,
    // which is what stops a write still pending in the aborted command.
    assign bus.cmd_ready   = rst_n && (state_q == S_IDLE);
    assign bus.busy        = rst_n && (state_q != S_IDLE);
    assign bus.done        = rst_n && (state_q == S_DONE);
    assign bus.mem_rd_en   = rst_n && rd_en;
    assign bus.mem_rd_addr = rst_n ? rd_addr : '0;
    assign bus.mem_wr_en   = rst_n && wr_en;
    assign bus.mem_wr_addr = rst_n ? wr_addr : '0;
    assign bus.mem_wr_data = (rst_n && wr_en) ? bus.lane_result : 8'h00;
    assign bus.lane_data1  = rst_n ? data1_q : 8'h00;
    assign bus.lane_data2  = rst_n ? data2_q : 8'h00;
    assign bus.lane_key    = rst_n ? key_q : 8'h00;
    assign bus.lane_select = rst_n ? sel_q : 4'h0;

endmodule

// File: tb/tb_lane_sequencer.sv
// Bench for lane_sequencer: a cycle-indexed expectation table is filled from each accepted
// command and compared against every DUT output on each falling edge.
module tb_lane_sequencer;

    localparam int ADDR_W = 8;
    localparam int TABN   = 2048;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lane_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    lane_sequencer #(.ADDR_W(ADDR_W), .MAX_LEN(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       ready;
        logic       busy;
        logic       done;
        logic       rd_en;
        logic [7:0] rd_addr;
        logic       wr_en;
        logic [7:0] wr_addr;
        logic [7:0] wr_data;
        logic       chk_lane;
        logic [7:0] d1;
        logic [7:0] d2;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic [7:0] mem [256];
    exp_t       tab [TABN];
    int         cyc = 0;
    bit         started = 1'b0;
    logic [3:0] sel_m = 4'h0;
    logic [7:0] key_m = 8'h00;
    bit         lane_zero_m = 1'b1;
    int         total = 0;
    int         bad = 0;
    ev_t        wr_log[$];
    ev_t        rd_log[$];
    int         done_log[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Environment lane: add, subtract, xor, shift-and.
    function automatic logic [7:0] lane_fn(input logic [7:0] d1, input logic [7:0] d2,
                                           input logic [7:0] key, input logic [3:0] sel);
        case (sel)
            4'd0:    return d1 + d2;
            4'd1:    return d1 - d2;
            4'd2:    return d1 ^ d2;
            default: return (d1 << key[2:0]) & d2;
        endcase
    endfunction

    assign bus.lane_result = lane_fn(bus.lane_data1, bus.lane_data2, bus.lane_key, bus.lane_select);

    always @(posedge clk) bus.mem_rd_data <= bus.mem_rd_en ? mem[bus.mem_rd_addr] : 8'hA5;

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    function automatic exp_t busy_e();
        exp_t e;
        e = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    task automatic put(input int idx, input exp_t e);
        if (idx < TABN) tab[idx] = e;
    endtask

    // Expected schedule of a command accepted in cycle c: element i reads at c+1+4i and c+2+4i,
    // writes at c+4+4i; done at c+4L+1.
    task automatic model_accept(input int c);
        int         len;
        logic [7:0] ra, rb, da, db;
        exp_t       e;
        len = (bus.cmd_len > 5'd16) ? 16 : int'(bus.cmd_len);
        sel_m = bus.cmd_select;
        key_m = bus.cmd_key;
        lane_zero_m = 1'b0;
        for (int i = 0; i < len; i++) begin
            ra = bus.cmd_src_a + 8'(i);
            rb = bus.cmd_src_b + 8'(i);
            da = mem[ra];
            db = mem[rb];
            e = busy_e(); e.rd_en = 1'b1; e.rd_addr = ra; put(c + 1 + 4*i, e);
            e = busy_e(); e.rd_en = 1'b1; e.rd_addr = rb; put(c + 2 + 4*i, e);
            e = busy_e();                                   put(c + 3 + 4*i, e);
            e = busy_e();
            e.wr_en = 1'b1;
            e.wr_addr = bus.cmd_dst + 8'(i);
            e.wr_data = lane_fn(da, db, bus.cmd_key, bus.cmd_select);
            e.chk_lane = 1'b1;
            e.d1 = da;
            e.d2 = db;
            put(c + 4 + 4*i, e);
        end
        e = busy_e(); e.done = 1'b1; put(c + 4*len + 1, e);
    endtask

    initial for (int k = 0; k < TABN; k++) tab[k] = idle_e();

    always @(posedge clk) begin
        if (!rst_n) begin
            sel_m = 4'h0;
            key_m = 8'h00;
            lane_zero_m = 1'b1;
            for (int k = cyc + 1; k < TABN; k++) tab[k] = idle_e();
        end else if (bus.cmd_valid && cyc < TABN && tab[cyc].ready) begin
            model_accept(cyc);
        end
        cyc = cyc + 1;
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started && cyc < TABN) begin
            exp_t        e;
            logic [40:0] g, w;
            e = rst_n ? tab[cyc] : '0;
            g = {bus.cmd_ready, bus.busy, bus.done, bus.mem_rd_en, bus.mem_rd_addr,
                 bus.mem_wr_en, bus.mem_wr_addr, bus.mem_wr_data, bus.lane_select, bus.lane_key};
            w = {e.ready, e.busy, e.done, e.rd_en, e.rd_addr, e.wr_en, e.wr_addr, e.wr_data,
                 (rst_n ? sel_m : 4'h0), (rst_n ? key_m : 8'h00)};
            check($sformatf("cyc%0d outputs", cyc), g, w);
            if (!rst_n || lane_zero_m)
                check($sformatf("cyc%0d lane zero", cyc), {bus.lane_data1, bus.lane_data2}, 16'h0);
            else if (e.chk_lane)
                check($sformatf("cyc%0d wb lane", cyc), {bus.lane_data1, bus.lane_data2}, {e.d1, e.d2});
        end
    end

    always @(negedge clk) begin
        if (started) begin
            if (bus.mem_wr_en) wr_log.push_back('{cyc, bus.mem_wr_addr, bus.mem_wr_data});
            if (bus.mem_rd_en) rd_log.push_back('{cyc, bus.mem_rd_addr, 8'h00});
            if (bus.done)      done_log.push_back(cyc);
        end
    end

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
        done_log.delete();
    endtask

    task automatic go_to(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic offer(input logic [3:0] sel, input logic [7:0] key, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] d, input logic [4:0] len);
        bus.cmd_select = sel;
        bus.cmd_key    = key;
        bus.cmd_src_a  = a;
        bus.cmd_src_b  = b;
        bus.cmd_dst    = d;
        bus.cmd_len    = len;
        bus.cmd_valid  = 1'b1;
    endtask

    task automatic await_accept(input string name, output int t);
        bit got;
        got = 1'b0;
        t = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                got = 1'b1;
                t = cyc;
            end
        end
        check({name, " accepted"}, 64'(got), 64'd1);
        @(posedge clk);
        #1;
        // Scramble the command fields afterwards; the latched copy must be unaffected.
        bus.cmd_valid  = 1'b0;
        bus.cmd_select = 4'hE;
        bus.cmd_key    = 8'hEE;
        bus.cmd_src_a  = 8'hEE;
        bus.cmd_src_b  = 8'hEE;
        bus.cmd_dst    = 8'hEE;
        bus.cmd_len    = 5'h1F;
    endtask

    task automatic wait_done(input string name, input int n, input int budget);
        int k;
        k = 0;
        while (done_log.size() < n && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        @(posedge clk);
        #1;
        check({name, " done count"}, 64'(done_log.size()), 64'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2;
        for (int k = 0; k < 256; k++) mem[k] = 8'(k * 13 + 7);
        mem[8'h10] = 8'h05; mem[8'h11] = 8'h07;
        mem[8'h20] = 8'h03; mem[8'h21] = 8'h02;
        bus.cmd_valid = 1'b0;
        bus.cmd_select = 4'h0; bus.cmd_key = 8'h00; bus.cmd_len = 5'd0;
        bus.cmd_src_a = 8'h00; bus.cmd_src_b = 8'h00; bus.cmd_dst = 8'h00;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready after reset", 64'(bus.cmd_ready), 64'd1);
        check("busy after reset", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;

        // Two-element add.
        clear_logs();
        offer(4'd0, 8'h00, 8'h10, 8'h20, 8'h30, 5'd2);
        await_accept("add2", t);
        wait_done("add2", 1, 40);
        check("add2 nwr", 64'(wr_log.size()), 64'd2);
        if (wr_log.size() >= 2) begin
            check("add2 wr0", {16'(wr_log[0].cyc), wr_log[0].addr, wr_log[0].data}, {16'(t + 4), 8'h30, 8'h08});
            check("add2 wr1", {16'(wr_log[1].cyc), wr_log[1].addr, wr_log[1].data}, {16'(t + 8), 8'h31, 8'h09});
        end
        if (done_log.size() >= 1) check("add2 done cyc", 64'(done_log[0]), 64'(t + 9));

        // Zero-length command.
        clear_logs();
        offer(4'd2, 8'h11, 8'h40, 8'h50, 8'h60, 5'd0);
        await_accept("len0", t);
        wait_done("len0", 1, 10);
        check("len0 nrd", 64'(rd_log.size()), 64'd0);
        check("len0 nwr", 64'(wr_log.size()), 64'd0);
        if (done_log.size() >= 1) check("len0 done cyc", 64'(done_log[0]), 64'(t + 1));

        // Address wrap at 0xFF.
        clear_logs();
        offer(4'd1, 8'h00, 8'hFF, 8'h7F, 8'hFE, 5'd3);
        await_accept("wrap", t);
        wait_done("wrap", 1, 40);
        check("wrap nrd", 64'(rd_log.size()), 64'd6);
        if (rd_log.size() >= 6)
            check("wrap rd addrs",
                  {rd_log[0].addr, rd_log[1].addr, rd_log[2].addr, rd_log[3].addr, rd_log[4].addr, rd_log[5].addr},
                  48'hFF7F_0080_0181);
        check("wrap nwr", 64'(wr_log.size()), 64'd3);
        if (wr_log.size() >= 3)
            check("wrap wr addrs", {wr_log[0].addr, wr_log[1].addr, wr_log[2].addr}, 24'hFEFF00);

        // Over-long command clamps to 16 elements.
        clear_logs();
        offer(4'd3, 8'h02, 8'h40, 8'h60, 8'h90, 5'd20);
        await_accept("clamp", t);
        wait_done("clamp", 1, 100);
        check("clamp nwr", 64'(wr_log.size()), 64'd16);
        if (wr_log.size() >= 16) check("clamp last addr", 64'(wr_log[15].addr), 64'h9F);
        if (done_log.size() >= 1) check("clamp done cyc", 64'(done_log[0]), 64'(t + 65));

        // Reset during the write-back of element 1.
        clear_logs();
        offer(4'd2, 8'h00, 8'h50, 8'h70, 8'hA0, 5'd4);
        await_accept("abort", t);
        go_to(t + 8);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort ready after release", 64'(bus.cmd_ready), 64'd1);
        repeat (20) @(posedge clk);
        #1;
        check("abort nwr", 64'(wr_log.size()), 64'd1);
        check("abort no done", 64'(done_log.size()), 64'd0);

        // Command offered while busy stays pending until IDLE.
        clear_logs();
        offer(4'd0, 8'h00, 8'h10, 8'h20, 8'hB0, 5'd1);
        await_accept("first", t);
        go_to(t + 2);
        offer(4'd2, 8'h00, 8'h11, 8'h21, 8'hB1, 5'd1);
        await_accept("pending", t2);
        check("pending accept cyc", 64'(t2), 64'(t + 6));
        wait_done("pending", 2, 40);
        check("pending nwr", 64'(wr_log.size()), 64'd2);
        if (wr_log.size() >= 2)
            check("pending wr", {wr_log[0].addr, wr_log[0].data, wr_log[1].addr, wr_log[1].data}, 32'hB008_B105);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
